// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants, opcode legality check, loader states and error codes.
// Used by the instruction loader and the control unit.
package isa_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_ADD  = 6'h00;
    localparam opcode_t OP_SUB  = 6'h01;
    localparam opcode_t OP_MOVE = 6'h21;
    localparam opcode_t OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone,
        StError
    } loader_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Legal set is the contiguous block OP_ADD..OP_MOVE plus the terminator.
    function automatic logic is_legal_opcode(input opcode_t op);
        return (op <= OP_MOVE) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Byte-to-word assembler: big-endian shift register, byte index, word-complete flag and
// the inter-byte idle timeout counter.
module instr_word_assembler #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        loadActive,
    input  logic        byteXfer,
    input  logic [7:0]  inData,
    output logic [31:0] word,
    output logic        wordFull,
    output logic        timeoutHit
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [1:0]      byteIdxQ, byteIdxD;
    logic [31:0]     wordQ, wordD;
    logic [CntW-1:0] idleCntQ, idleCntD;
    logic            counting;

    // Only a partially received word can time out.
    assign counting   = loadActive && (byteIdxQ != 2'd0) && !byteXfer;
    assign timeoutHit = counting && (idleCntQ == CntW'(TIMEOUT - 1));
    assign wordFull   = byteXfer && (byteIdxQ == 2'd3);
    assign word       = wordQ;

    always_comb begin
        byteIdxD = byteIdxQ;
        wordD    = wordQ;
        idleCntD = idleCntQ;
        if (clear) begin
            byteIdxD = 2'd0;
            idleCntD = '0;
        end else begin
            if (byteXfer) begin
                byteIdxD = byteIdxQ + 2'd1;
                wordD    = {wordQ[23:0], inData};
            end
            idleCntD = counting ? idleCntQ + CntW'(1) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byteIdxQ <= 2'd0;
            wordQ    <= '0;
            idleCntQ <= '0;
        end else begin
            byteIdxQ <= byteIdxD;
            wordQ    <= wordD;
            idleCntQ <= idleCntD;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: streams bytes into 32-bit words, screens opcodes and writes legal
// words to instruction memory, holding the core in reset until the terminator is loaded.
module instr_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    loader_state_e   stateQ, stateD;
    logic [ADDR_W-1:0] wordPtrQ, wordPtrD;
    logic [ADDR_W:0]   wordCountQ, wordCountD;
    logic [1:0]        errCodeQ, errCodeD;

    logic        startLoad;
    logic        writeEn;
    logic        byteXfer;
    logic [31:0] word;
    logic        wordFull;
    logic        timeoutHit;
    opcode_t     op;

    assign byteXfer = in_valid && in_ready;
    assign op       = word[31:26];

    instr_word_assembler #(
        .TIMEOUT(TIMEOUT)
    ) u_assembler (
        .clock     (clock),
        .reset     (reset),
        .clear     (startLoad),
        .loadActive(stateQ == StLoad),
        .byteXfer  (byteXfer),
        .inData    (in_data),
        .word      (word),
        .wordFull  (wordFull),
        .timeoutHit(timeoutHit)
    );

    always_comb begin
        stateD     = stateQ;
        wordPtrD   = wordPtrQ;
        wordCountD = wordCountQ;
        errCodeD   = errCodeQ;
        startLoad  = 1'b0;
        writeEn    = 1'b0;
        case (stateQ)
            StIdle, StDone, StError: begin
                if (start) begin
                    stateD     = StLoad;
                    wordPtrD   = '0;
                    wordCountD = '0;
                    errCodeD   = ERR_NONE;
                    startLoad  = 1'b1;
                end
            end
            StLoad: begin
                if (wordFull) begin
                    stateD = StWrite;
                end else if (timeoutHit) begin
                    stateD   = StError;
                    errCodeD = ERR_TIMEOUT;
                end
            end
            StWrite: begin
                if (!is_legal_opcode(op)) begin
                    stateD   = StError;
                    errCodeD = ERR_ILLEGAL;
                end else begin
                    writeEn    = 1'b1;
                    wordPtrD   = wordPtrQ + 1'b1;
                    wordCountD = wordCountQ + 1'b1;
                    // The terminator and the last in-range word are still written.
                    if (op == OP_HALT) begin
                        stateD = StDone;
                    end else if (wordPtrQ == {ADDR_W{1'b1}}) begin
                        stateD   = StError;
                        errCodeD = ERR_OVERFLOW;
                    end else begin
                        stateD = StLoad;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ     <= StIdle;
            wordPtrQ   <= '0;
            wordCountQ <= '0;
            errCodeQ   <= ERR_NONE;
        end else begin
            stateQ     <= stateD;
            wordPtrQ   <= wordPtrD;
            wordCountQ <= wordCountD;
            errCodeQ   <= errCodeD;
        end
    end

    assign in_ready   = (stateQ == StLoad);
    assign imem_we    = writeEn;
    assign imem_addr  = wordPtrQ;
    assign imem_wdata = writeEn ? word : 32'h0;
    assign cpu_hold   = (stateQ != StDone);
    assign busy       = (stateQ == StLoad) || (stateQ == StWrite);
    assign done       = (stateQ == StDone);
    assign error      = (stateQ == StError);
    assign err_code   = errCodeQ;
    assign word_count = wordCountQ;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a 4-word memory and an 8-cycle inter-byte timeout.
module tb_instr_loader;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;
    int weCount = 0;
    int hitCount = 0;
    int base;
    logic [31:0] mem [4];

    instr_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    // Memory model and write counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            mem[imem_addr] = imem_wdata;
            weCount++;
            if (imem_wdata == 32'h0011_2233) hitCount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present a byte and return at the negedge after it was accepted.
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("ready_wait", {31'b0, in_ready}, 32'h1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input logic gaps);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            sendByte(w[8*i +: 8]);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'h0);
        check({tag, "_imem_we"}, {31'b0, imem_we}, 32'h0);
        check({tag, "_imem_addr"}, {30'b0, imem_addr}, 32'h0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'h0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'h1);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_error"}, {31'b0, error}, 32'h0);
        check({tag, "_err_code"}, {30'b0, err_code}, 32'h0);
        check({tag, "_word_count"}, {29'b0, word_count}, 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clock);

        // Normal load of three words, last one the terminator.
        pulseStart();
        check("load_busy", {31'b0, busy}, 32'h1);
        check("load_ready", {31'b0, in_ready}, 32'h1);
        sendWord(32'h0400_0005, 1'b0);
        check("lat_we", {31'b0, imem_we}, 32'h1);
        check("lat_addr", {30'b0, imem_addr}, 32'h0);
        check("lat_wdata", imem_wdata, 32'h0400_0005);
        check("lat_ready_low", {31'b0, in_ready}, 32'h0);
        @(negedge clock);
        check("lat_ready_high", {31'b0, in_ready}, 32'h1);
        check("lat_we_low", {31'b0, imem_we}, 32'h0);
        check("lat_count", {29'b0, word_count}, 32'h1);
        sendWord(32'h4400_0000, 1'b0);
        sendWord(32'hFC00_0000, 1'b0);
        check("term_addr", {30'b0, imem_addr}, 32'h2);
        @(negedge clock);
        check("norm_done", {31'b0, done}, 32'h1);
        check("norm_hold", {31'b0, cpu_hold}, 32'h0);
        check("norm_count", {29'b0, word_count}, 32'h3);
        check("norm_busy", {31'b0, busy}, 32'h0);
        check("norm_writes", weCount, 32'd3);
        check("norm_mem0", mem[0], 32'h0400_0005);
        check("norm_mem1", mem[1], 32'h4400_0000);
        check("norm_mem2", mem[2], 32'hFC00_0000);

        // Illegal opcode 0x22 in the second word.
        base = weCount;
        pulseStart();
        check("ill_done_clr", {31'b0, done}, 32'h0);
        check("ill_hold", {31'b0, cpu_hold}, 32'h1);
        sendWord(32'h0C00_0007, 1'b0);
        sendWord(32'h8800_0000, 1'b0);
        check("ill_no_we", {31'b0, imem_we}, 32'h0);
        @(negedge clock);
        check("ill_error", {31'b0, error}, 32'h1);
        check("ill_code", {30'b0, err_code}, 32'h1);
        check("ill_count", {29'b0, word_count}, 32'h1);
        check("ill_cpu_hold", {31'b0, cpu_hold}, 32'h1);
        check("ill_writes", weCount - base, 32'd1);
        check("ill_mem0", mem[0], 32'h0C00_0007);

        // Gapped stream, then terminator.
        base = weCount;
        pulseStart();
        check("gap_err_clr", {31'b0, error}, 32'h0);
        sendWord(32'h0011_2233, 1'b1);
        sendWord(32'hFC00_0000, 1'b1);
        @(negedge clock);
        check("gap_done", {31'b0, done}, 32'h1);
        check("gap_hits", hitCount, 32'd1);
        check("gap_writes", weCount - base, 32'd2);

        // Overflow: four legal non-terminator words fill the memory.
        base = weCount;
        pulseStart();
        for (int i = 0; i < 4; i++) sendWord(32'h0400_00A0 + i, 1'b0);
        check("ovf_we", {31'b0, imem_we}, 32'h1);
        check("ovf_addr", {30'b0, imem_addr}, 32'h3);
        @(negedge clock);
        check("ovf_error", {31'b0, error}, 32'h1);
        check("ovf_code", {30'b0, err_code}, 32'h2);
        check("ovf_count", {29'b0, word_count}, 32'h4);
        check("ovf_writes", weCount - base, 32'd4);
        check("ovf_mem0", mem[0], 32'h0400_00A0);
        check("ovf_mem3", mem[3], 32'h0400_00A3);

        // Timeout after two bytes: still loading after 7 idle cycles, error after 8.
        base = weCount;
        pulseStart();
        check("to_code_clr", {30'b0, err_code}, 32'h0);
        sendByte(8'hAA);
        sendByte(8'hBB);
        repeat (7) @(negedge clock);
        check("to_not_yet", {31'b0, error}, 32'h0);
        check("to_busy", {31'b0, busy}, 32'h1);
        @(negedge clock);
        check("to_error", {31'b0, error}, 32'h1);
        check("to_code", {30'b0, err_code}, 32'h3);
        check("to_writes", weCount - base, 32'd0);

        // Reset mid-load, then a terminator-only load.
        pulseStart();
        sendByte(8'h11);
        sendByte(8'h22);
        reset = 1'b1;
        @(negedge clock);
        checkResetValues("midreset");
        reset = 1'b0;
        @(negedge clock);
        base = weCount;
        pulseStart();
        sendWord(32'hFC00_0001, 1'b0);
        check("rst_we", {31'b0, imem_we}, 32'h1);
        check("rst_addr", {30'b0, imem_addr}, 32'h0);
        @(negedge clock);
        check("rst_done", {31'b0, done}, 32'h1);
        check("rst_count", {29'b0, word_count}, 32'h1);
        check("rst_mem0", mem[0], 32'hFC00_0001);
        check("rst_writes", weCount - base, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
